// File: rtl/sha3_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sha3_padder
// Description : SHA3-256 message padder and rate-block assembler. Accepts
//               64-bit message words over ready/valid, applies the SHA-3
//               domain byte and pad10*1, and hands 1088-bit rate blocks to
//               the Keccak core through a double buffer (assembly + output).
// Ports       : clk, rst_n          - clock, async active-low reset
//               din/din_valid/din_last/din_bytes/din_ready - message input
//               blk/blk_valid/blk_more - rate block to core in/in_valid/more
//               hash_next/core_out_valid - core pacing feedback
//               busy               - message in flight
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_padder #(
    parameter int         RATE_WORDS = 17,
    parameter logic [7:0] DOMAIN     = 8'h06
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [63:0]                din,
    input  logic                       din_valid,
    input  logic                       din_last,
    input  logic [3:0]                 din_bytes,
    output logic                       din_ready,
    output logic [RATE_WORDS*64-1:0]   blk,
    output logic                       blk_valid,
    output logic                       blk_more,
    input  logic                       hash_next,
    input  logic                       core_out_valid,
    output logic                       busy
);

    localparam int                  c_TOP      = RATE_WORDS*64 - 1;
    localparam int                  c_WCNT_W   = $clog2(RATE_WORDS);
    localparam logic [c_WCNT_W-1:0] c_LAST_LANE = c_WCNT_W'(RATE_WORDS - 1);
    localparam logic [7:0]          c_PAD_END  = 8'h80;

    // The core consumes each byte bit-reversed in its field.
    function automatic logic [7:0] f_rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_TOP:0]      r_asm;
    logic                r_asm_full;
    logic                r_asm_more;
    logic                r_pend_pad;
    logic                r_out_full;
    logic [c_TOP:0]      r_blk;
    logic                r_blk_valid;
    logic                r_blk_more;
    logic                r_core_busy;

    logic [63:0]         w_lane;
    logic [c_TOP:0]      w_asm_next;
    logic [c_TOP:0]      w_pad_blk;
    int                  w_pad_pos;
    logic                w_accept;
    logic                w_full_last;
    logic                w_pad_now;
    logic                w_blk_done;
    logic                w_pad_load;
    logic                w_xfer;

    // Ready is forced low while reset is asserted.
    assign din_ready   = rst_n && !r_asm_full && !r_pend_pad;
    assign w_accept    = din_valid && din_ready;
    // Last word fills the final lane completely: padding needs its own block.
    assign w_full_last = din_last && (din_bytes == 4'd8) && (r_wcnt == c_LAST_LANE);
    assign w_pad_now   = din_last && !w_full_last;
    assign w_blk_done  = din_last || (r_wcnt == c_LAST_LANE);
    assign w_pad_load  = r_pend_pad && !r_asm_full;
    assign w_xfer      = r_asm_full && !r_out_full;

    // Incoming word: keep only the valid bytes of a final word, reversed per byte.
    always_comb begin
        w_lane = '0;
        for (int j = 0; j < 8; j++) begin
            if (!din_last || (4'(j) < din_bytes))
                w_lane[63-8*j -: 8] = f_rev8(din[63-8*j -: 8]);
        end
    end

    // Next assembly contents. A new block starts from zero so that bytes
    // left over from the previous block can never leak into this one.
    always_comb begin
        w_asm_next = (r_wcnt == '0) ? '0 : r_asm;
        w_asm_next[c_TOP - 64*int'(r_wcnt) -: 64] = w_lane;
        w_pad_pos = 8*int'(r_wcnt) + int'(din_bytes);
        if (w_pad_now) begin
            w_asm_next[c_TOP - 8*w_pad_pos -: 8] =
                w_asm_next[c_TOP - 8*w_pad_pos -: 8] | f_rev8(DOMAIN);
            w_asm_next[7:0] = w_asm_next[7:0] | f_rev8(c_PAD_END);
        end
    end

    // Padding-only block used when the message ends exactly on a block edge.
    always_comb begin
        w_pad_blk = '0;
        w_pad_blk[c_TOP -: 8] = f_rev8(DOMAIN);
        w_pad_blk[7:0]        = f_rev8(c_PAD_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt      <= '0;
            r_asm       <= '0;
            r_asm_full  <= 1'b0;
            r_asm_more  <= 1'b0;
            r_pend_pad  <= 1'b0;
            r_out_full  <= 1'b0;
            r_blk       <= '0;
            r_blk_valid <= 1'b0;
            r_blk_more  <= 1'b0;
            r_core_busy <= 1'b0;
        end else begin
            // Assembly side: accept, pad-only load and transfer are mutually
            // exclusive because accept and pad-load both require an empty
            // assembly register while transfer requires a full one.
            if (w_accept) begin
                r_asm <= w_asm_next;
                if (w_blk_done) begin
                    r_wcnt     <= '0;
                    r_asm_full <= 1'b1;
                    r_asm_more <= !w_pad_now;
                    r_pend_pad <= w_full_last;
                end else begin
                    r_wcnt <= r_wcnt + c_WCNT_W'(1);
                end
            end else if (w_pad_load) begin
                r_asm      <= w_pad_blk;
                r_asm_full <= 1'b1;
                r_asm_more <= 1'b0;
                r_pend_pad <= 1'b0;
            end else if (w_xfer) begin
                r_asm_full <= 1'b0;
            end

            // Output side: blk is only reloaded after the previous pulse.
            if (w_xfer) begin
                r_blk      <= r_asm;
                r_blk_more <= r_asm_more;
                r_out_full <= 1'b1;
            end else if (r_blk_valid) begin
                r_out_full <= 1'b0;
            end

            // Registered issue decision; hash_next never reaches blk_valid
            // combinationally.
            r_blk_valid <= r_out_full && !r_blk_valid && (!r_core_busy || hash_next);

            if (r_blk_valid)
                r_core_busy <= 1'b1;
            else if (core_out_valid)
                r_core_busy <= 1'b0;
        end
    end

    assign blk       = r_blk;
    assign blk_valid = r_blk_valid;
    assign blk_more  = r_blk_more;
    assign busy      = r_asm_full || r_out_full || r_core_busy || r_pend_pad;

endmodule
`default_nettype wire

// File: tb/tb_sha3_padder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha3_padder
// Description : Directed self-checking bench for sha3_padder with a simple
//               behavioural model of the core's hash_next/out_valid pacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_padder;

    localparam int c_COMP = 60;   // core compute cycles per block

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   din;
    logic          din_valid;
    logic          din_last;
    logic [3:0]    din_bytes;
    logic          din_ready;
    logic [1087:0] blk;
    logic          blk_valid;
    logic          blk_more;
    logic          hash_next;
    logic          core_out_valid;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hs_cyc  = 0;
    int max_stall = 0;

    logic [7:0]    msg [0:511];
    logic [1087:0] cap_blk  [0:15];
    logic          cap_more [0:15];
    int            cap_cyc  [0:15];
    int            nblk = 0;
    int            hn_rise = 0;
    int            mode = 0;
    int            ccnt = 0;
    logic          last_more = 1'b0;

    sha3_padder #(.RATE_WORDS(17), .DOMAIN(8'h06)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .din            (din),
        .din_valid      (din_valid),
        .din_last       (din_last),
        .din_bytes      (din_bytes),
        .din_ready      (din_ready),
        .blk            (blk),
        .blk_valid      (blk_valid),
        .blk_more       (blk_more),
        .hash_next      (hash_next),
        .core_out_valid (core_out_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Core pacing model: computes c_COMP cycles per block, then raises
    // hash_next (more=1) or pulses core_out_valid (more=0).
    initial begin
        hash_next = 1'b0;
        core_out_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            core_out_valid = 1'b0;
            if (!rst_n) begin
                mode = 0;
                hash_next = 1'b0;
            end else if (blk_valid) begin
                n_tests++;
                if (mode == 1) begin
                    n_fail++;
                    $display("FAIL issue_while_busy: blk_valid=1 at cycle %0d while core computing, required 0", cyc);
                end
                if (nblk < 16) begin
                    cap_blk[nblk]  = blk;
                    cap_more[nblk] = blk_more;
                    cap_cyc[nblk]  = cyc;
                end
                nblk++;
                hash_next = 1'b0;
                mode = 1;
                ccnt = c_COMP;
                last_more = blk_more;
            end else if (mode == 1) begin
                ccnt--;
                if (ccnt == 0) begin
                    if (last_more) begin
                        mode = 2;
                        hash_next = 1'b1;
                        hn_rise = cyc;
                    end else begin
                        mode = 0;
                        core_out_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Reference block built directly from the byte/bit mapping.
    function automatic logic [1087:0] model_blk(input int start, input int len, input bit pad);
        logic [1087:0] r;
        logic [7:0]    by;
        r = '0;
        for (int k = 0; k < 136; k++) begin
            by = (k < len) ? msg[start+k] : 8'h00;
            if (pad && k == len) by = by | 8'h06;
            if (pad && k == 135) by = by | 8'h80;
            for (int b = 0; b < 8; b++) r[1087-8*k-b] = by[b];
        end
        return r;
    endfunction

    function automatic int first_diff(input logic [1087:0] a, input logic [1087:0] b);
        for (int k = 0; k < 136; k++)
            if (a[1087-8*k -: 8] !== b[1087-8*k -: 8]) return k;
        return 0;
    endfunction

    task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] nb);
        int waited;
        waited = 0;
        din = w; din_last = last; din_bytes = nb; din_valid = 1'b1;
        while (!din_ready && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!din_ready) begin
            n_tests++; n_fail++;
            $display("FAIL din_ready_timeout: din_ready=%b after %0d cycles, required 1", din_ready, waited);
        end
        hs_cyc = cyc;
        if (waited > max_stall) max_stall = waited;
        @(posedge clk); #1;
    endtask

    task automatic send_msg(input int start, input int len);
        int nw;
        nw = (len == 0) ? 1 : (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            int rem;
            logic [63:0] word;
            logic last;
            rem  = len - 8*w;
            last = (w == nw - 1);
            for (int j = 0; j < 8; j++)
                word[63-8*j -: 8] = (j < rem) ? msg[start+8*w+j] : 8'hA5;
            send_word(word, last, last ? 4'(rem) : 4'd8);
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic wait_blocks(input int n);
        int t;
        t = 0;
        while (nblk < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (nblk < n) begin
            n_tests++; n_fail++;
            $display("FAIL block_timeout: %0d blocks seen, required %0d", nblk, n);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = '0; din_valid = 1'b0; din_last = 1'b0; din_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL rst_blk_valid: got %b required 0", blk_valid); end
        n_tests++; if (blk_more !== 1'b0) begin n_fail++; $display("FAIL rst_blk_more: got %b required 0", blk_more); end
        n_tests++; if (blk !== '0) begin n_fail++; $display("FAIL rst_blk: nonzero byte %0d got %h required 00", first_diff(blk, '0), blk[1087-8*first_diff(blk, '0) -: 8]); end
        n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL rst_din_ready: got %b required 0", din_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_din_ready: got %b required 1", din_ready); end
    endtask

    task automatic test_empty();
        int base;
        logic [1087:0] e;
        base = nblk;
        e = '0; e[1087:1080] = 8'h60; e[7:0] = 8'h01;
        send_msg(0, 0);
        wait_blocks(base + 1);
        n_tests++;
        if (cap_blk[base] !== e) begin n_fail++; $display("FAIL empty_blk: byte %0d got %h required %h", first_diff(cap_blk[base], e), cap_blk[base][1087-8*first_diff(cap_blk[base], e) -: 8], e[1087-8*first_diff(cap_blk[base], e) -: 8]); end
        n_tests++; if (cap_more[base] !== 1'b0) begin n_fail++; $display("FAIL empty_more: got %b required 0", cap_more[base]); end
        wait_idle();
    endtask

    task automatic test_abc();
        int base;
        logic [1087:0] e;
        base = nblk;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        e = '0; e[1087:1064] = 24'h8646C6; e[1063:1056] = 8'h60; e[7:0] = 8'h01;
        send_msg(0, 3);
        wait_blocks(base + 1);
        n_tests++;
        if (cap_blk[base] !== e) begin n_fail++; $display("FAIL abc_blk: byte %0d got %h required %h", first_diff(cap_blk[base], e), cap_blk[base][1087-8*first_diff(cap_blk[base], e) -: 8], e[1087-8*first_diff(cap_blk[base], e) -: 8]); end
        n_tests++; if (cap_more[base] !== 1'b0) begin n_fail++; $display("FAIL abc_more: got %b required 0", cap_more[base]); end
        n_tests++; if (cap_cyc[base] != hs_cyc + 3) begin n_fail++; $display("FAIL abc_latency: blk_valid %0d cycles after last word, required 3", cap_cyc[base] - hs_cyc); end
        wait_idle();
    endtask

    task automatic test_135();
        int base;
        logic [1087:0] e;
        base = nblk;
        for (int k = 0; k < 136; k++) msg[k] = 8'(k + 1);
        e = model_blk(0, 135, 1'b1);
        send_msg(0, 135);
        wait_blocks(base + 1);
        n_tests++;
        if (cap_blk[base] !== e) begin n_fail++; $display("FAIL m135_blk: byte %0d got %h required %h", first_diff(cap_blk[base], e), cap_blk[base][1087-8*first_diff(cap_blk[base], e) -: 8], e[1087-8*first_diff(cap_blk[base], e) -: 8]); end
        n_tests++; if (cap_blk[base][7:0] !== 8'h61) begin n_fail++; $display("FAIL m135_last_byte: got %h required 61", cap_blk[base][7:0]); end
        n_tests++; if (cap_more[base] !== 1'b0) begin n_fail++; $display("FAIL m135_more: got %b required 0", cap_more[base]); end
        wait_idle();
    endtask

    task automatic test_136();
        int base;
        logic [1087:0] e0;
        logic [1087:0] e1;
        base = nblk;
        for (int k = 0; k < 136; k++) msg[k] = 8'(3*k + 7);
        e0 = model_blk(0, 136, 1'b0);
        e1 = '0; e1[1087:1080] = 8'h60; e1[7:0] = 8'h01;
        send_msg(0, 136);
        wait_blocks(base + 2);
        n_tests++;
        if (cap_blk[base] !== e0) begin n_fail++; $display("FAIL m136_blk0: byte %0d got %h required %h", first_diff(cap_blk[base], e0), cap_blk[base][1087-8*first_diff(cap_blk[base], e0) -: 8], e0[1087-8*first_diff(cap_blk[base], e0) -: 8]); end
        n_tests++; if (cap_more[base] !== 1'b1) begin n_fail++; $display("FAIL m136_more0: got %b required 1", cap_more[base]); end
        n_tests++;
        if (cap_blk[base+1] !== e1) begin n_fail++; $display("FAIL m136_blk1: byte %0d got %h required %h", first_diff(cap_blk[base+1], e1), cap_blk[base+1][1087-8*first_diff(cap_blk[base+1], e1) -: 8], e1[1087-8*first_diff(cap_blk[base+1], e1) -: 8]); end
        n_tests++; if (cap_more[base+1] !== 1'b0) begin n_fail++; $display("FAIL m136_more1: got %b required 0", cap_more[base+1]); end
        n_tests++; if (cap_cyc[base+1] != hn_rise + 1) begin n_fail++; $display("FAIL m136_next_timing: blk_valid %0d cycles after hash_next, required 1", cap_cyc[base+1] - hn_rise); end
    endtask

    // Starts while the core is still busy with the previous message.
    task automatic test_back_to_back();
        int base;
        logic [1087:0] e;
        base = nblk;
        max_stall = 0;
        for (int k = 0; k < 300; k++) msg[k] = 8'(k*7) ^ 8'h5A;
        send_msg(0, 300);
        wait_blocks(base + 3);
        for (int i = 0; i < 3; i++) begin
            e = model_blk(136*i, (i < 2) ? 136 : 28, i == 2);
            n_tests++;
            if (cap_blk[base+i] !== e) begin n_fail++; $display("FAIL m300_blk%0d: byte %0d got %h required %h", i, first_diff(cap_blk[base+i], e), cap_blk[base+i][1087-8*first_diff(cap_blk[base+i], e) -: 8], e[1087-8*first_diff(cap_blk[base+i], e) -: 8]); end
            n_tests++;
            if (cap_more[base+i] !== (i < 2)) begin n_fail++; $display("FAIL m300_more%0d: got %b required %b", i, cap_more[base+i], (i < 2)); end
        end
        n_tests++; if (max_stall < 5) begin n_fail++; $display("FAIL m300_backpressure: longest din_ready stall %0d cycles, required >= 5", max_stall); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int base;
        logic [1087:0] e;
        for (int w = 0; w < 9; w++) send_word(64'h0123456789ABCDEF ^ 64'(w), 1'b0, 4'd8);
        din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++; if (blk !== '0) begin n_fail++; $display("FAIL mid_rst_blk: nonzero byte %0d got %h required 00", first_diff(blk, '0), blk[1087-8*first_diff(blk, '0) -: 8]); end
        n_tests++; if (blk_valid !== 1'b0 || blk_more !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: valid=%b more=%b required 0 0", blk_valid, blk_more); end
        n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_din_ready: got %b required 0", din_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        base = nblk;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        e = '0; e[1087:1064] = 24'h8646C6; e[1063:1056] = 8'h60; e[7:0] = 8'h01;
        send_msg(0, 3);
        wait_blocks(base + 1);
        n_tests++;
        if (cap_blk[base] !== e) begin n_fail++; $display("FAIL mid_rst_residue: byte %0d got %h required %h", first_diff(cap_blk[base], e), cap_blk[base][1087-8*first_diff(cap_blk[base], e) -: 8], e[1087-8*first_diff(cap_blk[base], e) -: 8]); end
        n_tests++; if (cap_more[base] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_more: got %b required 0", cap_more[base]); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_135();
        test_136();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
